// File: rtl/uart_axil_master.sv
// UART-to-AXI-Lite debug bridge: parses 0x57/0x52 command frames from the RX byte
// stream, issues one 32-bit AXI-Lite access and returns status (plus read data) on TX.
module uart_axil_master #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rx_valid_i,
    output logic                      rx_ready_o,
    input  logic [7:0]                rx_data_i,
    output logic                      tx_valid_o,
    input  logic                      tx_ready_i,
    output logic [7:0]                tx_data_o,
    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0] aw_addr_o,
    output logic [2:0]                aw_prot_o,
    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    output logic [31:0]               w_data_o,
    output logic [3:0]                w_strb_o,
    input  logic                      b_valid_i,
    output logic                      b_ready_o,
    input  logic [1:0]                b_resp_i,
    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0] ar_addr_o,
    output logic [2:0]                ar_prot_o,
    input  logic                      r_valid_i,
    output logic                      r_ready_o,
    input  logic [31:0]               r_data_i,
    input  logic [1:0]                r_resp_i,
    output logic                      busy_o,
    output logic [3:0]                state_o
);

    // Every channel handshake: a transfer happens on a rising clk_i edge where valid and
    // ready are both high; valid, once raised, holds with stable payload until that edge.
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_DATA, S_WR_REQ, S_WAIT_B,
        S_STATUS, S_RD_REQ, S_WAIT_R, S_RDATA
    } state_t;

    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);
    localparam logic [7:0]  CMD_WR    = 8'h57;
    localparam logic [7:0]  CMD_RD    = 8'h52;

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] tmo_q, tmo_d;
    logic        rx_ready_q, rx_ready_d;
    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        b_ready_q, b_ready_d;
    logic        ar_valid_q, ar_valid_d;
    logic        r_ready_q, r_ready_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;

    logic rx_fire, tx_fire, tmo_hit;
    assign rx_fire = rx_valid_i && rx_ready_q;
    assign tx_fire = tx_valid_q && tx_ready_i;
    assign tmo_hit = (TMO_LIMIT != 32'd0) && (tmo_q + 32'd1 == TMO_LIMIT);

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tmo_d      = tmo_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            S_IDLE: begin
                tmo_d = 32'd0;
                cnt_d = 2'd0;
                if (rx_fire && (rx_data_i == CMD_WR || rx_data_i == CMD_RD)) begin
                    is_wr_d = (rx_data_i == CMD_WR);
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    addr_d = {addr_q[23:0], rx_data_i};
                    tmo_d  = 32'd0;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d    = is_wr_q ? S_DATA : S_RD_REQ;
                        ar_valid_d = !is_wr_q;
                    end
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    data_d = {data_q[23:0], rx_data_i};
                    tmo_d  = 32'd0;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d    = S_WR_REQ;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            S_WR_REQ: begin
                // AW and W complete independently; leave only when both are done.
                if (aw_valid_q && aw_ready_i) aw_valid_d = 1'b0;
                if (w_valid_q && w_ready_i)   w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) begin
                    state_d   = S_WAIT_B;
                    b_ready_d = 1'b1;
                end
            end
            S_WAIT_B: begin
                if (b_valid_i && b_ready_q) begin
                    b_ready_d  = 1'b0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = (b_resp_i == 2'b00) ? 8'h4B : 8'h45;
                    state_d    = S_STATUS;
                end
            end
            S_RD_REQ: begin
                if (ar_ready_i) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (r_valid_i && r_ready_q) begin
                    r_ready_d  = 1'b0;
                    data_d     = r_data_i;
                    tx_valid_d = 1'b1;
                    tx_data_d  = (r_resp_i == 2'b00) ? 8'h4B : 8'h45;
                    state_d    = S_STATUS;
                end
            end
            S_STATUS: begin
                if (tx_fire) begin
                    if (is_wr_q) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_data_d = data_q[31:24];
                        data_d    = {data_q[23:0], 8'h00};
                        cnt_d     = 2'd0;
                        state_d   = S_RDATA;
                    end
                end
            end
            S_RDATA: begin
                if (tx_fire) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_data_d = data_q[31:24];
                        data_d    = {data_q[23:0], 8'h00};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            is_wr_q    <= 1'b0;
            cnt_q      <= 2'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            tmo_q      <= 32'd0;
            rx_ready_q <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tmo_q      <= tmo_d;
            rx_ready_q <= rx_ready_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_ready_o = rx_ready_q;
    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign aw_valid_o = aw_valid_q;
    assign aw_addr_o  = addr_q[AXI_ADDR_WIDTH-1:0];
    assign aw_prot_o  = 3'b000;
    assign w_valid_o  = w_valid_q;
    assign w_data_o   = data_q;
    assign w_strb_o   = 4'hF;
    assign b_ready_o  = b_ready_q;
    assign ar_valid_o = ar_valid_q;
    assign ar_addr_o  = addr_q[AXI_ADDR_WIDTH-1:0];
    assign ar_prot_o  = 3'b000;
    assign r_ready_o  = r_ready_q;
    assign busy_o     = busy_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_uart_axil_master.sv
// Bench for uart_axil_master: directed frames, a queue-based frame model of the expected
// AXI and TX traffic, and one negedge compare process checking every handshake.
module tb_uart_axil_master;

    localparam int AW  = 32;
    localparam int TMO = 100;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          rx_valid_i, rx_ready_o;
    logic [7:0]    rx_data_i;
    logic          tx_valid_o, tx_ready_i;
    logic [7:0]    tx_data_o;
    logic          aw_valid_o, aw_ready_i;
    logic [AW-1:0] aw_addr_o;
    logic [2:0]    aw_prot_o;
    logic          w_valid_o, w_ready_i;
    logic [31:0]   w_data_o;
    logic [3:0]    w_strb_o;
    logic          b_valid_i, b_ready_o;
    logic [1:0]    b_resp_i;
    logic          ar_valid_o, ar_ready_i;
    logic [AW-1:0] ar_addr_o;
    logic [2:0]    ar_prot_o;
    logic          r_valid_i, r_ready_o;
    logic [31:0]   r_data_i;
    logic [1:0]    r_resp_i;
    logic          busy_o;
    logic [3:0]    state_o;

    always #5 clk_i = ~clk_i;

    uart_axil_master #(.AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .busy_o(busy_o), .state_o(state_o)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  exp_tx[$];
    logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
    logic [7:0]  obs_tx[$];
    logic [31:0] obs_aw, obs_w, obs_ar;
    int          aw_hi, w_hi, ar_hi;
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, tx_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] status_of(input logic [1:0] resp);
        return (resp == 2'b00) ? 8'h4B : 8'h45;
    endfunction

    // Slave/TX sink: ready rises a configured number of cycles after valid is seen.
    initial begin
        logic tx_fired;
        int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0, tx_cnt = 0;
        aw_ready_i = 1'b0; w_ready_i = 1'b0; ar_ready_i = 1'b0; tx_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            tx_fired = tx_valid_o && tx_ready_i;
            @(posedge clk_i);
            #1;
            if (aw_valid_o) begin aw_ready_i = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin aw_ready_i = 1'b0; aw_cnt = 0; end
            if (w_valid_o) begin w_ready_i = (w_cnt >= w_dly); w_cnt++; end
            else begin w_ready_i = 1'b0; w_cnt = 0; end
            if (ar_valid_o) begin ar_ready_i = (ar_cnt >= ar_dly); ar_cnt++; end
            else begin ar_ready_i = 1'b0; ar_cnt = 0; end
            if (tx_valid_o) begin
                if (tx_fired) tx_cnt = 0;
                tx_ready_i = (tx_cnt >= tx_stall);
                tx_cnt++;
            end else begin
                tx_ready_i = 1'b0;
                tx_cnt = 0;
            end
        end
    end

    // Compare process: every handshake and hold rule checked against the model queues.
    initial begin
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("tx_hold_valid", tx_valid_o, 1);
                    chk("tx_hold_data", tx_data_o, prev_data);
                end
                if (tx_valid_o && tx_ready_i) begin
                    obs_tx.push_back(tx_data_o);
                    if (exp_tx.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL tx_extra: got %h expected no byte", tx_data_o);
                    end else chk("tx_byte", tx_data_o, exp_tx.pop_front());
                end
                prev_stall = tx_valid_o && !tx_ready_i;
                prev_data  = tx_data_o;
                if (aw_valid_o && aw_ready_i) begin
                    obs_aw = aw_addr_o;
                    chk("aw_prot", aw_prot_o, 0);
                    if (exp_aw.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL aw_extra: got %h expected no request", aw_addr_o);
                    end else chk("aw_addr", aw_addr_o, exp_aw.pop_front());
                end
                if (w_valid_o && w_ready_i) begin
                    obs_w = w_data_o;
                    chk("w_strb", w_strb_o, 4'hF);
                    if (exp_w.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL w_extra: got %h expected no request", w_data_o);
                    end else chk("w_data", w_data_o, exp_w.pop_front());
                end
                if (ar_valid_o && ar_ready_i) begin
                    obs_ar = ar_addr_o;
                    chk("ar_prot", ar_prot_o, 0);
                    if (exp_ar.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL ar_extra: got %h expected no request", ar_addr_o);
                    end else chk("ar_addr", ar_addr_o, exp_ar.pop_front());
                end
                if (tx_valid_o) chk("rx_ready_while_tx", rx_ready_o, 0);
                if (b_ready_o)  chk("b_ready_before_aw_w_done", aw_valid_o | w_valid_o, 0);
                if (r_ready_o)  chk("r_ready_before_ar_done", ar_valid_o, 0);
                if (aw_valid_o) aw_hi++;
                if (w_valid_o)  w_hi++;
                if (ar_valid_o) ar_hi++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        do begin
            @(negedge clk_i);
            n++;
        end while (!rx_ready_o && n < 1000);
        if (!rx_ready_o) begin
            n_cmp++; n_fail++;
            $display("FAIL rx_accept: got no rx_ready_o expected byte %h accepted", b);
        end
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        b_resp_i = resp;
        exp_aw.push_back(a);
        exp_w.push_back(d);
        exp_tx.push_back(status_of(resp));
        send_byte(8'h57);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] rd, input logic [1:0] resp);
        r_data_i = rd;
        r_resp_i = resp;
        exp_ar.push_back(a);
        exp_tx.push_back(status_of(resp));
        for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
        send_byte(8'h52);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    endtask

    task automatic wait_done(input string name);
        int pending;
        for (int i = 0; i < 3000; i++) begin
            pending = exp_tx.size() + exp_aw.size() + exp_w.size() + exp_ar.size() + int'(busy_o);
            if (pending == 0) break;
            @(posedge clk_i);
            #1;
        end
        pending = exp_tx.size() + exp_aw.size() + exp_w.size() + exp_ar.size() + int'(busy_o);
        chk(name, pending, 0);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic clear_obs();
        obs_tx.delete();
        obs_aw = '0; obs_w = '0; obs_ar = '0;
        aw_hi = 0; w_hi = 0; ar_hi = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, rx_ready_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_tx_valid"}, tx_valid_o, 0);
        chk({tag, "_tx_data"}, tx_data_o, 0);
        chk({tag, "_aw_valid"}, aw_valid_o, 0);
        chk({tag, "_w_valid"}, w_valid_o, 0);
        chk({tag, "_ar_valid"}, ar_valid_o, 0);
        chk({tag, "_b_ready"}, b_ready_o, 0);
        chk({tag, "_r_ready"}, r_ready_o, 0);
        chk({tag, "_aw_addr"}, aw_addr_o, 0);
        chk({tag, "_ar_addr"}, ar_addr_o, 0);
        chk({tag, "_w_data"}, w_data_o, 0);
    endtask

    initial begin
        logic [7:0] lit_rd[5];
        rst_i = 1'b1;
        rx_valid_i = 1'b0; rx_data_i = 8'h00;
        b_valid_i = 1'b1; b_resp_i = 2'b00;
        r_valid_i = 1'b1; r_data_i = 32'h0; r_resp_i = 2'b00;
        clear_obs();
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_outputs("reset");
        rst_i = 1'b0;
        chk("rx_ready_before_first_edge", rx_ready_o, 0);
        @(posedge clk_i);
        #1;
        chk("rx_ready_after_reset", rx_ready_o, 1);

        // Plain write
        clear_obs();
        do_write(32'h0000_1004, 32'hDEAD_BEEF, 2'b00);
        wait_done("wr_done");
        chk("wr_aw_lit", obs_aw, 32'h0000_1004);
        chk("wr_w_lit", obs_w, 32'hDEAD_BEEF);
        chk("wr_tx_count", obs_tx.size(), 1);
        chk("wr_tx_lit", obs_tx[0], 8'h4B);

        // Plain read
        clear_obs();
        do_read(32'h0000_0008, 32'h1234_5678, 2'b00);
        wait_done("rd_done");
        lit_rd = '{8'h4B, 8'h12, 8'h34, 8'h56, 8'h78};
        chk("rd_ar_lit", obs_ar, 32'h0000_0008);
        chk("rd_tx_count", obs_tx.size(), 5);
        for (int i = 0; i < 5; i++) chk("rd_tx_lit", obs_tx[i], lit_rd[i]);

        // AW late by 5 cycles, W immediate, SLVERR
        clear_obs();
        aw_dly = 5; w_dly = 0;
        do_write(32'hA000_0010, 32'h0BAD_F00D, 2'b10);
        wait_done("skew_done");
        chk("skew_aw_cycles", aw_hi, 6);
        chk("skew_w_cycles", w_hi, 1);
        chk("skew_tx_lit", obs_tx[0], 8'h45);
        aw_dly = 0;

        // TX backpressure on a read with an error response
        clear_obs();
        tx_stall = 10;
        do_read(32'h0000_0100, 32'hCAFE_F00D, 2'b01);
        wait_done("bp_done");
        lit_rd = '{8'h45, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        chk("bp_tx_count", obs_tx.size(), 5);
        for (int i = 0; i < 5; i++) chk("bp_tx_lit", obs_tx[i], lit_rd[i]);
        tx_stall = 0;

        // Partial frame then silence: frame is discarded after TMO idle cycles
        clear_obs();
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (TMO - 1) @(posedge clk_i);
        #1;
        chk("tmo_busy_before", busy_o, 1);
        @(posedge clk_i);
        #1;
        chk("tmo_busy_after", busy_o, 0);
        chk("tmo_rx_ready_after", rx_ready_o, 1);
        chk("tmo_no_axi", aw_hi + w_hi + ar_hi, 0);
        do_read(32'h0000_0020, 32'h8765_4321, 2'b00);
        wait_done("tmo_read_done");
        chk("tmo_read_ar_lit", obs_ar, 32'h0000_0020);
        chk("tmo_read_tx_lit", obs_tx[4], 8'h21);

        // Garbage in IDLE
        clear_obs();
        send_byte(8'hFF);
        send_byte(8'h00);
        repeat (20) @(posedge clk_i);
        #1;
        chk("garbage_no_tx", obs_tx.size(), 0);
        chk("garbage_busy", busy_o, 0);
        chk("garbage_no_axi", aw_hi + w_hi + ar_hi, 0);

        // Reset while waiting for R
        clear_obs();
        r_valid_i = 1'b0;
        do_read(32'h0000_0044, 32'h5555_AAAA, 2'b00);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (r_ready_o) break;
        end
        chk("wait_r_reached", r_ready_o, 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        exp_tx.delete();
        @(posedge clk_i);
        #1;
        chk_reset_outputs("midreset");
        rst_i = 1'b0;
        r_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("midreset_rx_ready_back", rx_ready_o, 1);
        chk("midreset_no_tx", obs_tx.size(), 0);

        // Normal operation after the mid-access reset
        clear_obs();
        do_write(32'h0000_0FFC, 32'h0000_0001, 2'b00);
        wait_done("post_reset_done");
        chk("post_reset_tx_lit", obs_tx[0], 8'h4B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_cmp++; n_fail++;
        $display("FAIL watchdog: got no end of test expected completion before 500000 ns");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
